// File: rtl/ifft_frame_streamer_pkg.sv
// ifft_frame_streamer_pkg: FSM state type and default frame geometry shared by the streamer.
package ifft_frame_streamer_pkg;
  typedef enum logic [2:0] {IDLE, CONFIG, STREAM, DRAIN, DONE} state_e;
  localparam int FRAME_LEN_DEF = 1024;
  localparam int ADDR_STEP_DEF = 4;
endpackage

// File: rtl/ifft_frame_streamer_if.sv
// ifft_frame_streamer_if: BRAM read port plus the config and data AXI-Stream channels.
interface ifft_frame_streamer_if #(
  parameter int NCH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CFG_W = 16
);
  logic [ADDR_W-1:0] bram_addr;
  logic bram_en;
  logic [NCH*DATA_W-1:0] bram_dout;
  logic [CFG_W-1:0] m_cfg_tdata;
  logic m_cfg_tvalid, m_cfg_tready;
  logic [NCH*DATA_W-1:0] m_dat_tdata;
  logic m_dat_tvalid, m_dat_tlast, m_dat_tready;
  modport master (
    output bram_addr, bram_en, m_cfg_tdata, m_cfg_tvalid, m_dat_tdata, m_dat_tvalid, m_dat_tlast,
    input bram_dout, m_cfg_tready, m_dat_tready
  );
  modport slave (
    input bram_addr, bram_en, m_cfg_tdata, m_cfg_tvalid, m_dat_tdata, m_dat_tvalid, m_dat_tlast,
    output bram_dout, m_cfg_tready, m_dat_tready
  );
endinterface

// File: rtl/ifft_frame_streamer_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO whose head entry drives the stream output directly.
module stream_skid_fifo #(
  parameter int W = 8
) (
  input logic clk,
  input logic resetn,
  input logic push_i,
  input logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic valid_o,
  input logic ready_i,
  output logic [1:0] count_o
);
  logic [W-1:0] mem_q [2];
  logic wr_q, rd_q, pop;
  logic [1:0] cnt_q;
  assign valid_o = cnt_q != 2'd0;
  assign pop = valid_o & ready_i;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop);
    end
  end
endmodule

// File: rtl/ifft_frame_streamer.sv
// ifft_frame_streamer: sends one config word per run, then streams FRAME_LEN-sample frames
// from BRAM to NCH lockstep IFFT channels until the frame count or a stop request ends the run.
module ifft_frame_streamer
  import ifft_frame_streamer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DATA_W = 32,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W = 32,
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter int CFG_W = 16
) (
  input logic clk,
  input logic resetn,
  input logic start,
  input logic stop,
  input logic continuous,
  input logic [15:0] num_frames,
  input logic [CFG_W-1:0] cfg_word,
  ifft_frame_streamer_if.master bus,
  output logic busy,
  output logic done,
  output logic [15:0] frame_cnt
);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int DW = NCH * DATA_W;
  state_e state_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0] nfr_q, issued_q, frame_cnt_q;
  logic [CFG_W-1:0] cfg_q;
  logic cont_q, stop_q, infl_q, infl_last_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] fifo_cnt;
  logic [DW:0] head;
  logic head_valid, pop, issue, at_last, more;
  assign pop = head_valid & bus.m_dat_tready;
  // Credits include this cycle's pop so a continuously ready sink sees no bubbles.
  assign issue = (state_q == STREAM) && (({1'b0, fifo_cnt} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign at_last = idx_q == IDX_W'(FRAME_LEN - 1);
  assign more = !(stop_q | stop) &&
                (cont_q || (17'(issued_q) + 17'd1 < 17'(nfr_q == 16'd0 ? 16'd1 : nfr_q)));
  assign addr_d = issue ? ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP) : addr_q;
  assign bus.bram_en = issue;
  assign bus.bram_addr = addr_d;
  assign bus.m_cfg_tdata = cfg_q;
  assign bus.m_cfg_tvalid = state_q == CONFIG;
  assign bus.m_dat_tvalid = head_valid;
  assign bus.m_dat_tlast = head_valid & head[DW];
  assign bus.m_dat_tdata = head[DW-1:0];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign frame_cnt = frame_cnt_q;
  stream_skid_fifo #(.W(DW + 1)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push_i(infl_q),
    .data_i({infl_last_q, bus.bram_dout}),
    .data_o(head),
    .valid_o(head_valid),
    .ready_i(bus.m_dat_tready),
    .count_o(fifo_cnt)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      nfr_q <= '0;
      issued_q <= '0;
      frame_cnt_q <= '0;
      cfg_q <= '0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
      addr_q <= '0;
    end else begin
      infl_q <= issue;
      infl_last_q <= issue & at_last;
      addr_q <= addr_d;
      stop_q <= busy & (stop_q | stop);
      if (pop && head[DW]) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (issue) idx_q <= idx_q + IDX_W'(1);
      if (issue && at_last) issued_q <= issued_q + 16'd1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= CONFIG;
          cfg_q <= cfg_word;
          cont_q <= continuous;
          nfr_q <= num_frames;
          frame_cnt_q <= '0;
          issued_q <= '0;
          idx_q <= '0;
        end
        CONFIG: if (bus.m_cfg_tready) state_q <= STREAM;
        STREAM: if (issue && at_last && !more) state_q <= DRAIN;
        DRAIN: if (pop && head[DW]) state_q <= DONE;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft_frame_streamer.sv
// tb_ifft_frame_streamer: randomized runs checked against a frame-level model of the sample stream.
module tb_ifft_frame_streamer;
  localparam int NCH = 2, DATA_W = 16, F = 16, STEP = 8, DW = NCH * DATA_W;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [15:0] num_frames = '0, cfg_word = '0, frame_cnt, cfg_exp = '0;
  logic busy, done;
  logic [DW-1:0] mem [F];
  int n_chk = 0, n_pass = 0;
  int beats = 0, reads = 0, cfg_hs = 0, dones = 0;
  bit rnd_rdy = 1'b0;

  ifft_frame_streamer_if #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(32), .CFG_W(16)) bus ();

  ifft_frame_streamer #(
    .NCH(NCH), .DATA_W(DATA_W), .FRAME_LEN(F), .ADDR_W(32), .ADDR_STEP(STEP), .CFG_W(16)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .continuous(continuous),
    .num_frames(num_frames), .cfg_word(cfg_word), .bus(bus),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM holding one frame of random samples.
  always @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[int'(bus.bram_addr) / STEP % F];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {bus.bram_en, bus.m_cfg_tvalid, bus.m_dat_tvalid, bus.m_dat_tlast, busy, done}, 0);
    check({tag, "_addr"}, bus.bram_addr, 0);
    check({tag, "_cfg"}, bus.m_cfg_tdata, 0);
    check({tag, "_tdata"}, bus.m_dat_tdata, 0);
    check({tag, "_frames"}, frame_cnt, 0);
  endtask

  // Beat k of a run must carry sample k mod F, with tlast on the last sample of each frame.
  task automatic monitor();
    bit stalled = 1'b0;
    int last_addr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        beats = 0;
        reads = 0;
        stalled = 1'b0;
        last_addr = 0;
      end else begin
        if (start && !busy) begin
          beats = 0;
          reads = 0;
          cfg_hs = 0;
          dones = 0;
        end
        if (bus.m_cfg_tvalid) begin
          check("cfg_quiet", {bus.bram_en, bus.m_dat_tvalid}, 0);
          check("cfg_data", bus.m_cfg_tdata, cfg_exp);
          if (bus.m_cfg_tready) cfg_hs++;
        end
        if (bus.bram_en) begin
          last_addr = (reads % F) * STEP;
          reads++;
          check("addr", bus.bram_addr, last_addr);
        end else check("addr_hold", bus.bram_addr, last_addr);
        if (stalled) check("stall_hold", {bus.m_dat_tvalid, bus.m_dat_tdata}, {1'b1, mem[beats % F]});
        if (bus.m_dat_tvalid && bus.m_dat_tready) begin
          check("frame_cnt", frame_cnt, beats / F);
          check("tdata", bus.m_dat_tdata, mem[beats % F]);
          check("tlast", bus.m_dat_tlast, beats % F == F - 1);
          beats++;
        end
        stalled = bus.m_dat_tvalid && !bus.m_dat_tready;
        if (done) dones++;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1 bus.m_dat_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic launch(input bit cont, input int nfr, input bit rnd, input int cfg_wait);
    cfg_exp = 16'($urandom);
    cfg_word = cfg_exp;
    continuous = cont;
    num_frames = 16'(nfr);
    rnd_rdy = rnd;
    bus.m_cfg_tready = cfg_wait == 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_word = ~cfg_exp;
    num_frames = 16'd7;
  endtask

  task automatic run(input bit cont, input int nfr, input int stop_at, input bit rnd,
                     input int cfg_wait, input int exp_fr);
    bit stopped = 1'b0;
    launch(cont, nfr, rnd, cfg_wait);
    for (int i = 0; i < 4000 && dones == 0; i++) begin
      if (i + 1 >= cfg_wait) bus.m_cfg_tready = 1'b1;
      stop = stop_at >= 0 && !stopped && beats >= stop_at;
      stopped |= stop;
      start = i == 30;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", dones, 1);
    check("cfg_beats", cfg_hs, 1);
    check("beats", beats, exp_fr * F);
    check("reads", reads, exp_fr * F);
    check("frame_cnt_end", frame_cnt, exp_fr);
    check("busy_end", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < F; i++) mem[i] = DW'($urandom);
    bus.m_cfg_tready = 1'b1;
    bus.m_dat_tready = 1'b1;
    fork
      monitor();
      drive_ready();
    join_none
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check_idle("por");
    run(1'b0, 2, -1, 1'b0, 0, 2);
    run(1'b0, 3, -1, 1'b1, 0, 3);
    run(1'b0, 0, -1, 1'b1, 20, 1);
    run(1'b1, 5, F + F / 2, 1'b0, 0, 2);
    run(1'b1, 0, 0, 1'b1, 6, 1);
    launch(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 500 && beats < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_beats", beats >= 20, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    check_idle("rst");
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_beats", beats, 0);
    check("post_rst_busy", busy, 0);
    run(1'b0, 1, -1, 1'b0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
